seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.
//  Holds a 16-bit hex value and drives one digit at a time through COMM, with SEG decoded
//  from that digit's nibble. A blanking gap between digits suppresses ghosting.
//  A new value is accepted by valid/ready handshake and applied only at a frame boundary,
//  so a frame never shows a mix of old and new digits. Sits between counter logic and pins.
// PARAMETERS
//  DIGIT_CYCLES  12000  cycles each digit is driven (1 ms at 12 MHz); must be >= 1
//  BLANK_CYCLES  120    cycles all digits are off before each digit; 0 = no gap
// PORTS
//  CLK         in   1   system clock (12 MHz board clock)
//  RST         in   1   synchronous reset, active high
//  VALUE       in   16  value to display; [3:0]=digit0 ... [15:12]=digit3
//  LOAD_VALID  in   1   VALUE is valid this cycle
//  LOAD_READY  out  1   pending buffer is empty; transfer when LOAD_VALID & LOAD_READY
//  BLANK_EN    in   4   per-digit blank; bit i high keeps digit i dark (sampled live)
//  SEG         out  7   segments {g,f,e,d,c,b,a}, active low
//  COMM        out  4   digit anodes, active high, at most one bit high
//  FRAME_DONE  out  1   one-cycle pulse on the last DRIVE cycle of digit 3
// BEHAVIOUR
//  Clock: CLK only. Reset: synchronous, active-high RST.
//  Reset (on any edge where RST=1, including mid-frame): state BLANK, digit=0, dwell count=0,
//   shadow=16'h0000, pending empty -> SEG=7'h7F, COMM=4'b0000, LOAD_READY=1, FRAME_DONE=0.
//  FSM: BLANK -> DRIVE -> BLANK ... Digit index advances 0->1->2->3->0 on each DRIVE exit.
//   BLANK: lasts BLANK_CYCLES cycles; COMM=0, SEG=7'h7F. If BLANK_CYCLES=0, BLANK is skipped.
//   DRIVE: lasts DIGIT_CYCLES cycles; COMM=one-hot(digit), SEG=hex(shadow nibble[digit]).
//    If BLANK_EN[digit]=1 then COMM=0, SEG=7'h7F, but timing is unchanged.
//  Frame period is 4*(BLANK_CYCLES+DIGIT_CYCLES) cycles, fixed and independent of BLANK_EN/loads.
//  SEG, COMM and FRAME_DONE are registered and updated on the same edge as the FSM, so they
//   always match the current state. They have no extra cycle of lag and never glitch.
//  Hex decode (active low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0011000 A=0001000 b=0000011 C=1000110 d=0100001
//   E=0000110 F=0001110.
//  Handshake: LOAD_READY = pending empty. On LOAD_VALID&LOAD_READY, pending<=VALUE and the
//   pending buffer becomes full (LOAD_READY=0 the next cycle). LOAD_VALID while not ready is ignored;
//   the source must hold it.
//  Frame boundary = the FRAME_DONE cycle. If pending is full there, shadow<=pending and the
//   pending buffer empties. New digits appear from the next digit-0 DRIVE onward.
//  Simultaneous accept and frame boundary: this cannot occur with a full pending buffer. The
//   accepted value waits one full frame.
//  Dwell counter width is $clog2(max(DIGIT_CYCLES,BLANK_CYCLES)+1). It wraps to 0 on every
//   state exit and has no overflow path.
// TESTING (bench params DIGIT_CYCLES=4, BLANK_CYCLES=2 -> 24-cycle frame)
//  1. Hold RST 3 cycles, then release -> SEG=7'h7F, COMM=0, LOAD_READY=1. First frame shows
//     0000: COMM=0001 with SEG=1000000 for 4 cycles, starting 2 cycles after release.
//  2. Load 16'h1234 in frame 0 -> from frame 1: d0 SEG=0011001 COMM=0001 (4 cyc), blank 2,
//     d1 0110000/0010, d2 0100100/0100, d3 1111001/1000. FRAME_DONE every 24 cycles.
//  3. Load 16'hAAAA, then hold LOAD_VALID with 16'h5555 -> LOAD_READY=0 until the boundary.
//     5555 is accepted the cycle after that boundary, shows one frame later, and AAAA shows in between.
//  4. BLANK_EN=4'b0100 with 16'h8888 -> COMM[2] never high. SEG=7'h7F in d2's slot. Other digits
//     are 0000000, and the 24-cycle period is unchanged.
//  5. BLANK_CYCLES=0 -> COMM rotates 0001,0010,0100,1000 every 4 cycles and is never 0 after reset exit.
//  6. Assert RST for 1 cycle during d2 DRIVE with pending full -> next cycle COMM=0, SEG=7'h7F,
//     LOAD_READY=1. The following frame shows 0000.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Load channel for the seven-segment scan controller.
// The producer presents a 16-bit hex value under a valid/ready handshake.
interface seg_scan_ctrl_if;
  logic [15:0] value;
  logic        load_valid;
  logic        load_ready;

  modport master (output value, output load_valid, input load_ready);
  modport slave  (input value, input load_valid, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
// New values are double-buffered and swapped in only at a frame boundary.
module seg_scan_ctrl #(
  parameter int DIGIT_CYCLES = 12000,
  parameter int BLANK_CYCLES = 120
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave load,
  input  logic [3:0]     blank_en,
  output logic [6:0]     seg,
  output logic [3:0]     comm,
  output logic           frame_done
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       comm_q, comm_d;
  logic             frame_done_q, frame_done_d;
  logic             accept;
  logic             lit;
  logic [3:0]       nibble;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Scan sequencing: BLANK and DRIVE alternate, with BLANK skipped entirely when no gap is configured.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      ST_BLANK: begin
        if (!HAS_BLANK || cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = HAS_BLANK ? ST_BLANK : ST_DRIVE;
          digit_d = digit_q + 2'd1;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // The pending buffer drains only on the FRAME_DONE cycle, so an accept can never collide with it.
  always_comb begin
    accept      = load.load_valid && !pend_full_q;
    pend_d      = accept ? load.value : pend_q;
    pend_full_d = pend_full_q;
    if (accept) begin
      pend_full_d = 1'b1;
    end else if (frame_done_q) begin
      pend_full_d = 1'b0;
    end
    shadow_d = (frame_done_q && pend_full_q) ? pend_q : shadow_q;
  end

  // Outputs are computed from the next state so the registered pins line up with the FSM.
  always_comb begin
    case (digit_d)
      2'd0:    nibble = shadow_d[3:0];
      2'd1:    nibble = shadow_d[7:4];
      2'd2:    nibble = shadow_d[11:8];
      default: nibble = shadow_d[15:12];
    endcase
    lit          = (state_d == ST_DRIVE) && !blank_en[digit_d];
    comm_d       = lit ? (4'b0001 << digit_d) : 4'b0000;
    seg_d        = lit ? hex7(nibble) : 7'h7F;
    frame_done_d = (state_d == ST_DRIVE) && (digit_d == 2'd3) && (cnt_d == DRIVE_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      digit_q      <= 2'd0;
      cnt_q        <= '0;
      shadow_q     <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_full_q  <= 1'b0;
      seg_q        <= 7'h7F;
      comm_q       <= 4'b0000;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      seg_q        <= seg_d;
      comm_q       <= comm_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load.load_ready = !pend_full_q;
  assign seg             = seg_q;
  assign comm            = comm_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a frame scoreboard on the gapped instance plus a
// cycle-by-cycle rotation check on a second instance with no blanking gap.
module tb_seg_scan_ctrl;

  localparam int DIGIT  = 4;
  localparam int PERIOD = 24;

  typedef struct packed {
    logic [3:0][6:0] seg;
    logic [3:0]      mask;
  } frame_t;

  logic       clk;
  logic       rst;
  logic [3:0] blankEn;
  logic [6:0] seg, seg0;
  logic [3:0] comm, comm0;
  logic       frameDone, frameDone0;
  logic       rstAtEdge = 1'b1;

  int checkCount = 0;
  int errorCount = 0;

  frame_t expQ[$];

  seg_scan_ctrl_if ldIf ();
  seg_scan_ctrl_if ld0If ();

  seg_scan_ctrl #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .load(ldIf.slave), .blank_en(blankEn),
    .seg(seg), .comm(comm), .frame_done(frameDone)
  );

  seg_scan_ctrl #(.DIGIT_CYCLES(4), .BLANK_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .load(ld0If.slave), .blank_en(4'b0000),
    .seg(seg0), .comm(comm0), .frame_done(frameDone0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rstAtEdge <= rst;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic vld);
    ldIf.value      = v;
    ldIf.load_valid = vld;
  endtask

  task automatic pushFrame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                           input logic [6:0] s0, input logic [3:0] mask);
    frame_t f;
    f.seg[0] = s0;
    f.seg[1] = s1;
    f.seg[2] = s2;
    f.seg[3] = s3;
    f.mask   = mask;
    expQ.push_back(f);
  endtask

  task automatic finishRun();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  endtask

  task automatic waitFrameDone();
    int n = 0;
    @(negedge clk);
    while (!frameDone && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!frameDone) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL frame_done_timeout: got 0, expected a pulse within 100 cycles");
      finishRun();
    end
  endtask

  // Frame monitor: accumulates what each digit showed, then scores it against the next expected frame.
  int         cycCnt = 0;
  int         drvCnt[4];
  logic [6:0] segSeen[4];
  logic       glitch = 1'b0;

  always @(negedge clk) begin
    int idx;
    frame_t e;
    if (rstAtEdge) begin
      cycCnt = 0;
      glitch = 1'b0;
      for (int i = 0; i < 4; i++) begin
        drvCnt[i]  = 0;
        segSeen[i] = 7'h7F;
      end
    end
    cycCnt++;
    if (comm != 4'b0000) begin
      if ($onehot(comm)) begin
        idx = comm[0] ? 0 : comm[1] ? 1 : comm[2] ? 2 : 3;
        drvCnt[idx]++;
        if (drvCnt[idx] == 1) segSeen[idx] = seg;
        else if (seg !== segSeen[idx]) glitch = 1'b1;
      end else begin
        glitch = 1'b1;
      end
    end else if (seg !== 7'h7F) begin
      glitch = 1'b1;
    end
    if (frameDone === 1'b1) begin
      checkOutput("sb_has_expected", expQ.size() > 0, 1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("frame_period", cycCnt, PERIOD);
        checkOutput("frame_clean", glitch, 0);
        for (int i = 0; i < 4; i++) begin
          checkOutput($sformatf("digit%0d_dwell", i), drvCnt[i], e.mask[i] ? 0 : DIGIT);
          if (!e.mask[i]) checkOutput($sformatf("digit%0d_seg", i), segSeen[i], e.seg[i]);
        end
      end
      cycCnt = 0;
      glitch = 1'b0;
      for (int i = 0; i < 4; i++) begin
        drvCnt[i]  = 0;
        segSeen[i] = 7'h7F;
      end
    end
  end

  // Gapless instance: digits rotate every 4 cycles from the first cycle after reset release.
  initial begin
    logic [3:0] expComm;
    ld0If.value      = 16'h0000;
    ld0If.load_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      expComm = 4'b0001 << ((k / 4) % 4);
      checkOutput("noblank_comm", comm0, expComm);
      checkOutput("noblank_frame_done", frameDone0, (k % 16) == 15);
      if (k < 31) @(negedge clk);
    end
    checkOutput("noblank_seg", seg0, 7'b1000000);
  end

  initial begin
    int n;
    rst     = 1'b1;
    blankEn = 4'b0000;
    applyStimulus(16'h0000, 1'b0);
    pushFrame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_seg", seg, 7'h7F);
    checkOutput("reset_comm", comm, 4'b0000);
    checkOutput("reset_ready", ldIf.load_ready, 1);
    checkOutput("reset_frame_done", frameDone, 0);

    @(negedge clk);
    checkOutput("blank_before_d0", comm, 4'b0000);
    applyStimulus(16'h1234, 1'b1);
    pushFrame(7'h79, 7'h24, 7'h30, 7'h19, 4'b0000);
    @(negedge clk);
    applyStimulus(16'h1234, 1'b0);
    checkOutput("first_d0_comm", comm, 4'b0001);
    checkOutput("first_d0_seg", seg, 7'b1000000);
    checkOutput("ready_after_accept", ldIf.load_ready, 0);

    waitFrameDone();
    @(negedge clk);
    checkOutput("ready_after_swap", ldIf.load_ready, 1);
    applyStimulus(16'hAAAA, 1'b1);
    pushFrame(7'h08, 7'h08, 7'h08, 7'h08, 4'b0000);
    @(negedge clk);
    checkOutput("ready_full_aaaa", ldIf.load_ready, 0);
    applyStimulus(16'h5555, 1'b1);
    pushFrame(7'h12, 7'h12, 7'h12, 7'h12, 4'b0000);
    waitFrameDone();
    checkOutput("ready_held_to_boundary", ldIf.load_ready, 0);
    @(negedge clk);
    checkOutput("ready_after_boundary", ldIf.load_ready, 1);
    @(negedge clk);
    checkOutput("ready_5555_accepted", ldIf.load_ready, 0);
    applyStimulus(16'h5555, 1'b0);

    waitFrameDone();
    @(negedge clk);
    checkOutput("ready_for_8888", ldIf.load_ready, 1);
    applyStimulus(16'h8888, 1'b1);
    pushFrame(7'h00, 7'h7F, 7'h00, 7'h00, 4'b0100);
    @(negedge clk);
    applyStimulus(16'h8888, 1'b0);
    checkOutput("ready_full_8888", ldIf.load_ready, 0);
    waitFrameDone();
    blankEn = 4'b0100;
    waitFrameDone();
    blankEn = 4'b0000;

    @(negedge clk);
    applyStimulus(16'hFFFF, 1'b1);
    @(negedge clk);
    applyStimulus(16'hFFFF, 1'b0);
    checkOutput("ready_full_ffff", ldIf.load_ready, 0);
    n = 0;
    while (comm !== 4'b0100 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_d2_drive", comm, 4'b0100);
    rst = 1'b1;
    pushFrame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midframe_reset_seg", seg, 7'h7F);
    checkOutput("midframe_reset_comm", comm, 4'b0000);
    checkOutput("midframe_reset_ready", ldIf.load_ready, 1);
    checkOutput("midframe_reset_frame_done", frameDone, 0);
    waitFrameDone();
    repeat (2) @(negedge clk);
    checkOutput("sb_drained", expQ.size(), 0);
    finishRun();
  end

endmodule
